// File: rtl/pmod_led_ctrl_if.sv
// Pmod-to-LED signal bundle: raw input, mode switches, LED drive and press count.
// The controller takes the slave side; the board top-level or bench takes the master side.
interface pmod_led_ctrl_if;
  logic       ja;
  logic [1:0] mode;
  logic       led;
  logic [7:0] press_count;

  modport master (
    output ja,
    output mode,
    input  led,
    input  press_count
  );

  modport slave (
    input  ja,
    input  mode,
    output led,
    output press_count
  );
endinterface

// File: rtl/pmod_led_ctrl.sv
// Debounced Pmod input to LED controller with PASS/TOGGLE/BLINK/STRETCH modes.
// Define PMOD_PRESS_COUNT_EN to build the press counter; otherwise press_count is 0.
module pmod_led_ctrl #(
  parameter int DB_CYCLES    = 1_000_000,
  parameter int BLINK_HALF   = 25_000_000,
  parameter int PULSE_CYCLES = 50_000_000
) (
  input logic             clk,
  input logic             rst_n,
  pmod_led_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    PASS    = 2'b00,
    TOGGLE  = 2'b01,
    BLINK   = 2'b10,
    STRETCH = 2'b11
  } mode_e;

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);
  localparam int PW  = $clog2(PULSE_CYCLES + 1);

  logic           s0;
  logic           s1;
  logic           stable;
  logic           stable_d;
  logic [DBW-1:0] db_cnt;
  mode_e          mode_q;
  mode_e          mode_n;
  logic [BW-1:0]  blink_cnt;
  logic [PW-1:0]  pulse_cnt;
  logic           led_q;
  logic           rise;
  logic           mode_chg;

  assign mode_n   = mode_e'(bus.mode);
  assign rise     = stable & ~stable_d;
  assign mode_chg = (mode_n != mode_q);
  assign bus.led  = led_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0       <= 1'b0;
      s1       <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      db_cnt   <= '0;
      mode_q   <= PASS;
    end else begin
      s0       <= bus.ja;
      s1       <= s0;
      stable_d <= stable;
      mode_q   <= mode_n;
      if (s1 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
        stable <= s1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  // A mode switch blanks the LED for one cycle and wins over a coincident rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q     <= 1'b0;
      blink_cnt <= '0;
      pulse_cnt <= '0;
    end else if (mode_chg) begin
      led_q     <= 1'b0;
      blink_cnt <= '0;
      pulse_cnt <= '0;
    end else begin
      unique case (mode_q)
        PASS: begin
          led_q <= stable;
        end
        TOGGLE: begin
          led_q <= led_q ^ rise;
        end
        BLINK: begin
          if (!stable) begin
            led_q     <= 1'b0;
            blink_cnt <= '0;
          end else if (rise) begin
            led_q     <= 1'b1;
            blink_cnt <= '0;
          end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
            led_q     <= ~led_q;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
        STRETCH: begin
          if (rise) begin
            pulse_cnt <= PW'(PULSE_CYCLES);
            led_q     <= 1'b1;
          end else if (pulse_cnt > PW'(1)) begin
            pulse_cnt <= pulse_cnt - PW'(1);
          end else if (pulse_cnt == PW'(1)) begin
            pulse_cnt <= '0;
            led_q     <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef PMOD_PRESS_COUNT_EN
  logic [7:0] press_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_q <= 8'd0;
    end else if (rise) begin
      press_q <= press_q + 8'd1;
    end
  end

  assign bus.press_count = press_q;
`else
  assign bus.press_count = 8'd0;
`endif

endmodule

// File: tb/tb_pmod_led_ctrl.sv
// Bench for pmod_led_ctrl: directed and random ja/mode/reset stimulus
// compared every cycle against a time-based behavioural model.
module tb_pmod_led_ctrl;

  localparam int DB = 4;
  localparam int BH = 3;
  localparam int PC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pmod_led_ctrl_if bus ();

  pmod_led_ctrl #(
    .DB_CYCLES    (DB),
    .BLINK_HALF   (BH),
    .PULSE_CYCLES (PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  // Model state: LED derived from edge timestamps rather than counters.
  bit       m_s0, m_s1, m_stable, m_stable_d;
  bit       m_hist[$];
  bit [1:0] m_mode_q;
  bit       m_led;
  bit       m_base;
  int       m_t = 0;
  int       m_anchor = 0;
  int       m_deadline = 0;
  int       m_presses = 0;

  function automatic logic [7:0] exp_count();
`ifdef PMOD_PRESS_COUNT_EN
    return 8'(m_presses);
`else
    return 8'd0;
`endif
  endfunction

  task automatic model_edge();
    bit rise;
    bit chg;
    bit flip;
    bit old_stable;
    rise = m_stable && !m_stable_d;
    if (!rst_n) begin
      m_s0 = 0; m_s1 = 0; m_stable = 0; m_stable_d = 0;
      m_hist.delete();
      m_mode_q = 2'd0;
      m_led = 0;
      m_anchor = m_t; m_base = 0;
      m_deadline = 0;
      m_presses = 0;
    end else begin
      chg = (bus.mode != m_mode_q);
      if (rise) m_presses++;
      if (chg) begin
        m_led = 0;
        m_anchor = m_t; m_base = 0;
        m_deadline = 0;
      end else begin
        case (m_mode_q)
          2'd0: m_led = m_stable;
          2'd1: m_led = m_led ^ rise;
          2'd2: begin
            if (!m_stable) begin
              m_led = 0; m_anchor = m_t; m_base = 0;
            end else if (rise) begin
              m_led = 1; m_anchor = m_t; m_base = 1;
            end else begin
              m_led = m_base ^ (((m_t - m_anchor) / BH) % 2 == 1);
            end
          end
          default: begin
            if (rise) begin
              m_led = 1; m_deadline = m_t + PC;
            end else begin
              m_led = (m_t < m_deadline);
            end
          end
        endcase
      end
      // Stable level flips once s1 has disagreed for DB consecutive edges.
      old_stable = m_stable;
      m_hist.push_back(m_s1);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      flip = (m_hist.size() == DB);
      foreach (m_hist[i]) if (m_hist[i] == m_stable) flip = 0;
      if (flip) m_stable = m_s1;
      m_stable_d = old_stable;
      m_s1 = m_s0;
      m_s0 = bus.ja;
      m_mode_q = bus.mode;
    end
    m_t++;
  endtask

  task automatic check();
    vectors++;
    assert (bus.led === m_led) else begin
      errors++;
      $error("FAIL led t=%0d observed %b expected %b", m_t, bus.led, m_led);
    end
    vectors++;
    assert (bus.press_count === exp_count()) else begin
      errors++;
      $error("FAIL press_count t=%0d observed %0d expected %0d",
             m_t, bus.press_count, exp_count());
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check();
    end
  endtask

  task automatic press(input int hi, input int lo);
    bus.ja = 1'b1;
    tick(hi);
    bus.ja = 1'b0;
    tick(lo);
  endtask

  initial begin
    int hi_cnt;
    logic [7:0] base;
    bus.ja   = 1'b1;
    bus.mode = 2'b00;
    rst_n    = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    bus.ja = 1'b0;
    tick(12);

    // Glitch shorter than the debounce window, then one just long enough.
    press(3, 10);
    press(4, 12);

    bus.mode = 2'b01;
    tick(2);
    for (int i = 0; i < 3; i++) press(10, 10);

    bus.mode = 2'b10;
    tick(2);
    press(20, 10);

    bus.mode = 2'b11;
    tick(2);
    hi_cnt = 0;
    bus.ja = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      hi_cnt += int'(bus.led);
    end
    bus.ja = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      hi_cnt += int'(bus.led);
    end
    vectors++;
    assert (hi_cnt === PC) else begin
      errors++;
      $error("FAIL stretch_width observed %0d expected %0d", hi_cnt, PC);
    end

    // Fastest possible second press, then leave STRETCH mid-pulse.
    press(5, 5);
    press(5, 2);
    bus.mode = 2'b00;
    tick(10);

    bus.mode = 2'b11;
    tick(2);
    press(7, 1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(12);

    bus.mode = 2'b01;
    tick(2);
    base = bus.press_count;
    for (int i = 0; i < 256; i++) press(6, 6);
    vectors++;
    assert (bus.press_count === exp_count()) else begin
      errors++;
      $error("FAIL press_wrap observed %0d expected %0d (start %0d)",
             bus.press_count, exp_count(), base);
    end

    for (int i = 0; i < 300; i++) begin
      bus.ja = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick(int'($urandom_range(1, 2)));
        rst_n = 1'b1;
      end
      tick(int'($urandom_range(1, 12)));
    end

    bus.ja = 1'b0;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pmod_led_ctrl.md
# pmod_led_ctrl

Debounced controller for the Pmod-input-to-LED path on the lab board. It synchronizes and debounces the single Pmod line, detects presses, and drives the LED in one of four switch-selected modes: pass-through, toggle, blink-while-held or pulse-stretch. It also keeps a press counter. It sits between the board pins and the LED in the lab top-level.

## Interface
Parameters:
- DB_CYCLES, 1_000_000 — consecutive stable cycles needed to accept a new input level (10 ms at 100 MHz); must be ≥ 1.
- BLINK_HALF, 25_000_000 — LED half-period in BLINK mode, in cycles; must be ≥ 1.
- PULSE_CYCLES, 50_000_000 — LED on-time in STRETCH mode, in cycles; must be ≥ 1.

Ports:
- clk  in  1  system clock (100 MHz).
- rst_n  in  1  reset; one clock; reset is synchronous and active-low.
- ja  in  1  raw, asynchronous Pmod input.
- mode  in  2  00 PASS, 01 TOGGLE, 10 BLINK, 11 STRETCH. Driven from switches and treated as synchronous.
- led  out  1  registered LED drive.
- press_count  out  8  number of debounced rising edges seen, modulo 256.

## Operation
- Synchronizer: a 2-flop chain, ja → s0 → s1.
- Debouncer: holds `stable` and a counter `db_cnt`.
  - If s1 == stable: db_cnt ← 0.
  - Else if db_cnt == DB_CYCLES-1: stable ← s1 and db_cnt ← 0.
  - Else: db_cnt ← db_cnt + 1.
  - Any glitch shorter than DB_CYCLES cycles at s1 is ignored.
- Edge detect: a register stable_d follows stable; rise = stable & ~stable_d (combinational, one cycle wide).
- Mode register: mode_q ← mode every cycle.
  - On any cycle where mode ≠ mode_q, the mode-change rule applies: led ← 0, blink counter ← 0, pulse counter ← 0.
  - The new mode takes effect from the next cycle.
  - The mode-change rule has priority over a coincident rise for led. That rise is still counted in press_count.
- Mode behaviour (updates at each edge):
  - PASS: led ← stable.
  - TOGGLE: led ← led ^ rise.
  - BLINK:
    - If stable = 0: led ← 0 and blink counter ← 0.
    - On rise: led ← 1 and blink counter ← 0.
    - Otherwise, while stable = 1: the blink counter counts 0..BLINK_HALF-1; at BLINK_HALF-1, led toggles and the counter wraps to 0.
  - STRETCH:
    - On rise: pulse counter ← PULSE_CYCLES and led ← 1.
    - Else if pulse counter > 1: decrement the counter; led stays 1.
    - Else if pulse counter == 1: counter ← 0 and led ← 0.
    - A rise during an active pulse reloads the counter (retrigger).
- Press counter: press_count ← press_count + 1 on every rise, in every mode. It wraps from 255 to 0.

## Timing
- Reset (rst_n = 0 at an edge) clears everything: s0, s1, stable, stable_d, db_cnt, mode_q, blink counter, pulse counter, led = 0 and press_count = 0.
  - mode_q is cleared to 00, so a non-PASS mode held through reset triggers one mode-change cycle right after release.
  - Reset asserted mid-pulse or mid-blink forces led = 0 at that edge.
- Input latency: let E be the first edge sampling ja = 1 while it stays high.
  - stable rises at edge E+1+DB_CYCLES.
  - led responds at edge E+2+DB_CYCLES, in every mode.
- Release latency is the same: the falling ja edge reaches stable after 1+DB_CYCLES edges.
- STRETCH: led is high for exactly PULSE_CYCLES clock cycles after the last rise.
- BLINK: the first toggle comes BLINK_HALF cycles after the rise edge. The period is then 2·BLINK_HALF cycles.
- press_count updates on the same edge as led's response to a rise.

## Configuration
- PMOD_PRESS_COUNT_EN:
  - Defined: the press_count counter is implemented as described.
  - Undefined: the counter logic is omitted and press_count is tied to 8'd0.
  - led behaviour is identical either way.

## Test plan
All scenarios use DB_CYCLES=4, BLINK_HALF=3, PULSE_CYCLES=5.
- Reset and latency: hold rst_n=0 for 3 cycles with ja=1, then release in PASS mode → led=0 and press_count=0 during reset; led=1 at 6 edges after the first post-reset edge; press_count=1.
- Glitch rejection: in PASS mode, ja=1 for 3 cycles then 0 → led never rises and press_count stays 0. Then ja=1 for 4 cycles → led rises.
- TOGGLE: 3 clean presses (ja high 10 cycles, low 10 cycles) → led sequence 1, 0, 1; press_count=3.
- BLINK: hold ja high for 20 cycles → led=1 for 3 cycles, 0 for 3, 1 for 3, and so on. Release → led=0 one edge after stable falls.
- STRETCH retrigger: press, then press again 3 cycles after the first rise → led high for exactly 3+5=8 cycles in total. A mode change to PASS mid-pulse → led=0 on the next edge.
- Wrap and macro: 256 presses → press_count returns to 0. With PMOD_PRESS_COUNT_EN undefined, press_count is constantly 0 while led behaviour is unchanged.
